// File: rtl/spec_power_avg.sv
// spec_power_avg: streaming re^2+im^2 per FFT bin, averaged over 2^AVG_LOG2 frames
// through a per-bin accumulator RAM; feeds the log10/dB stage with a 1-cycle enable.
module spec_power_avg #(
    parameter int DATA_W   = 16,
    parameter int NFFT     = 512,
    parameter int ADDR_W   = 9,
    parameter int AVG_LOG2 = 2,
    parameter int OUT_W    = 41
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic                     i_sop,
    input  logic signed [DATA_W-1:0] i_re,
    input  logic signed [DATA_W-1:0] i_im,
    output logic                     o_en,
    output logic [OUT_W-1:0]         o_power,
    output logic [ADDR_W-1:0]        o_bin,
    output logic                     o_frame_done,
    output logic                     o_err_short,
    output logic                     o_err_ovr
);

    localparam int SQW   = 2*DATA_W - 1;
    localparam int PW    = 2*DATA_W;
    localparam int ACC_W = PW + AVG_LOG2;
    localparam int FC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [ADDR_W-1:0] LAST_BIN   = ADDR_W'(NFFT - 1);
    localparam logic [FC_W-1:0]   FRAME_LAST = FC_W'((1 << AVG_LOG2) - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_bin_cnt;
    logic [FC_W-1:0]    r_frame_cnt;

    logic               w_accept;
    logic               w_short;
    logic               w_ovr;
    logic [ADDR_W-1:0]  w_bin;
    logic [FC_W-1:0]    w_frame;

    logic                     r_v1, r_first1, r_last1;
    logic signed [DATA_W-1:0] r_re1, r_im1;
    logic [ADDR_W-1:0]        r_bin1;

    logic                     r_v2, r_first2, r_last2;
    logic [SQW-1:0]           r_re_sq, r_im_sq;
    logic [ADDR_W-1:0]        r_bin2;
    logic [ACC_W-1:0]         r_rd2;

    logic                     r_v3, r_first3, r_last3;
    logic [PW-1:0]            r_p3;
    logic [ACC_W-1:0]         r_acc_rd3;
    logic [ADDR_W-1:0]        r_bin3;

    logic signed [PW-1:0]     w_re_full, w_im_full;
    logic [PW-1:0]            w_p;
    logic [ACC_W-1:0]         w_acc_new;
    logic [PW-1:0]            w_avg;

    logic [ACC_W-1:0]         r_mem [NFFT];

    // Classify the incoming sample: which bin/frame it belongs to, or why it is rejected.
    always_comb begin
        w_accept = 1'b0;
        w_short  = 1'b0;
        w_ovr    = 1'b0;
        w_bin    = '0;
        w_frame  = r_frame_cnt;
        if (i_valid) begin
            if (r_state == IDLE) begin
                if (i_sop) begin
                    w_accept = 1'b1;
                    w_frame  = '0;
                end
            end else if (i_sop) begin
                w_accept = 1'b1;
                if (r_bin_cnt != LAST_BIN) begin
                    w_short = 1'b1;
                    w_frame = '0;
                end
            end else if (r_bin_cnt == LAST_BIN) begin
                w_ovr = 1'b1;
            end else begin
                w_accept = 1'b1;
                w_bin    = r_bin_cnt + 1'b1;
            end
        end
    end

    assign w_re_full = r_re1 * r_re1;
    assign w_im_full = r_im1 * r_im1;
    assign w_p       = {1'b0, r_re_sq} + {1'b0, r_im_sq};
    assign w_acc_new = r_first3 ? ACC_W'(r_p3) : r_acc_rd3 + ACC_W'(r_p3);
    assign w_avg     = PW'(w_acc_new >> AVG_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bin_cnt    <= '0;
            r_frame_cnt  <= '0;
            o_err_short  <= 1'b0;
            o_err_ovr    <= 1'b0;
            r_v1         <= 1'b0;
            r_first1     <= 1'b0;
            r_last1      <= 1'b0;
            r_re1        <= '0;
            r_im1        <= '0;
            r_bin1       <= '0;
            r_v2         <= 1'b0;
            r_first2     <= 1'b0;
            r_last2      <= 1'b0;
            r_re_sq      <= '0;
            r_im_sq      <= '0;
            r_bin2       <= '0;
            r_v3         <= 1'b0;
            r_first3     <= 1'b0;
            r_last3      <= 1'b0;
            r_p3         <= '0;
            r_acc_rd3    <= '0;
            r_bin3       <= '0;
            o_en         <= 1'b0;
            o_power      <= '0;
            o_bin        <= '0;
            o_frame_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state   <= RUN;
                r_bin_cnt <= w_bin;
                // Frame count advances after the last bin, so that bin keeps its own frame tag.
                if (w_bin == LAST_BIN)
                    r_frame_cnt <= (w_frame == FRAME_LAST) ? '0 : w_frame + 1'b1;
                else
                    r_frame_cnt <= w_frame;
            end else if (w_ovr) begin
                r_state <= IDLE;
            end
            o_err_short <= w_short;
            o_err_ovr   <= w_ovr;

            r_v1 <= w_accept;
            if (w_accept) begin
                r_re1    <= i_re;
                r_im1    <= i_im;
                r_bin1   <= w_bin;
                r_first1 <= (w_frame == '0);
                r_last1  <= (w_frame == FRAME_LAST);
            end

            r_v2     <= r_v1;
            r_re_sq  <= SQW'(w_re_full);
            r_im_sq  <= SQW'(w_im_full);
            r_bin2   <= r_bin1;
            r_first2 <= r_first1;
            r_last2  <= r_last1;

            r_v3      <= r_v2;
            r_p3      <= w_p;
            r_acc_rd3 <= r_rd2;
            r_bin3    <= r_bin2;
            r_first3  <= r_first2;
            r_last3   <= r_last2;

            o_en         <= r_v3 && r_last3;
            o_frame_done <= r_v3 && r_last3 && (r_bin3 == LAST_BIN);
            if (r_v3 && r_last3) begin
                o_power <= (w_avg == '0) ? OUT_W'(1) : OUT_W'(w_avg);
                o_bin   <= r_bin3;
            end
        end
    end

    // Same bin recurs at least NFFT samples later, so read-before-write needs no bypass.
    always_ff @(posedge clk) begin
        if (r_v3)
            r_mem[r_bin3] <= w_acc_new;
        r_rd2 <= r_mem[r_bin1];
    end

endmodule

// File: tb/tb_spec_power_avg.sv
// Testbench for spec_power_avg: table-driven constant-frame vectors plus hand sequences,
// checked against a per-bin averaging reference model through a scoreboard queue.
module tb_spec_power_avg;

    localparam int DATA_W   = 16;
    localparam int NFFT     = 8;
    localparam int ADDR_W   = 3;
    localparam int AVG_LOG2 = 2;
    localparam int OUT_W    = 41;
    localparam int NFR      = 1 << AVG_LOG2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     i_valid = 1'b0;
    logic                     i_sop = 1'b0;
    logic signed [DATA_W-1:0] i_re = '0;
    logic signed [DATA_W-1:0] i_im = '0;
    logic                     o_en;
    logic [OUT_W-1:0]         o_power;
    logic [ADDR_W-1:0]        o_bin;
    logic                     o_frame_done;
    logic                     o_err_short;
    logic                     o_err_ovr;

    always #5 clk = ~clk;

    spec_power_avg #(
        .DATA_W  (DATA_W),
        .NFFT    (NFFT),
        .ADDR_W  (ADDR_W),
        .AVG_LOG2(AVG_LOG2),
        .OUT_W   (OUT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_sop       (i_sop),
        .i_re        (i_re),
        .i_im        (i_im),
        .o_en        (o_en),
        .o_power     (o_power),
        .o_bin       (o_bin),
        .o_frame_done(o_frame_done),
        .o_err_short (o_err_short),
        .o_err_ovr   (o_err_ovr)
    );

    typedef struct {
        int     due;
        int     bin;
        longint pwr;
        bit     done;
    } exp_t;

    typedef struct {
        int     re;
        int     im;
        longint pwr;
    } vec_t;

    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;

    bit     m_run = 1'b0;
    int     m_bin = 0;
    int     m_frame = 0;
    longint m_acc [NFFT];
    bit     exp_short = 1'b0;
    bit     exp_ovr = 1'b0;

    int     n_en = 0;
    int     n_short = 0;
    int     n_ovr = 0;
    longint last_pwr = 0;
    longint pwr_bin2 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: check outputs produced so far, then drive the next input and update the model.
    task automatic step(input bit v, input bit sop, input int re, input int im);
        exp_t   e;
        bit     acc;
        bit     sh;
        bit     ov;
        int     bin;
        int     fr;
        longint p;
        longint avg;
        @(negedge clk);
        cyc++;
        chk("err_short", o_err_short, exp_short);
        chk("err_ovr", o_err_ovr, exp_ovr);
        if (o_err_short) n_short++;
        if (o_err_ovr) n_ovr++;
        if (o_en) begin
            n_en++;
            last_pwr = o_power;
            if (o_bin == 2) pwr_bin2 = o_power;
            if (sb.size() == 0) begin
                chk("unexpected_en", o_en, 0);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc, e.due);
                chk("bin", o_bin, e.bin);
                chk("power", o_power, e.pwr);
                chk("frame_done", o_frame_done, e.done);
                chk("power_msb", o_power[OUT_W-1], 0);
            end
        end else begin
            chk("frame_done_idle", o_frame_done, 0);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("missing_en", o_en, 1);
            end
        end

        i_valid = v;
        i_sop   = sop;
        i_re    = DATA_W'(re);
        i_im    = DATA_W'(im);

        acc = 1'b0; sh = 1'b0; ov = 1'b0; bin = 0; fr = m_frame;
        if (v) begin
            if (!m_run) begin
                if (sop) begin acc = 1'b1; fr = 0; end
            end else if (sop) begin
                acc = 1'b1;
                if (m_bin != NFFT - 1) begin sh = 1'b1; fr = 0; end
            end else if (m_bin == NFFT - 1) begin
                ov = 1'b1;
                m_run = 1'b0;
            end else begin
                acc = 1'b1;
                bin = m_bin + 1;
            end
        end
        if (acc) begin
            p = longint'(re) * re + longint'(im) * im;
            if (fr == 0) m_acc[bin] = p;
            else         m_acc[bin] = m_acc[bin] + p;
            if (fr == NFR - 1) begin
                avg = m_acc[bin] >> AVG_LOG2;
                if (avg == 0) avg = 1;
                e.due  = cyc + 4;
                e.bin  = bin;
                e.pwr  = avg;
                e.done = (bin == NFFT - 1);
                sb.push_back(e);
            end
            m_run   = 1'b1;
            m_bin   = bin;
            m_frame = (bin == NFFT - 1) ? (fr + 1) % NFR : fr;
        end
        exp_short = sh;
        exp_ovr   = ov;
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        m_run = 1'b0; m_bin = 0; m_frame = 0;
        exp_short = 1'b0; exp_ovr = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            i_valid = 1'($urandom);
            i_sop   = 1'($urandom);
            i_re    = DATA_W'($urandom);
            i_im    = DATA_W'($urandom);
            @(negedge clk);
            chk("rst_en", o_en, 0);
            chk("rst_power", o_power, 0);
            chk("rst_bin", o_bin, 0);
            chk("rst_done", o_frame_done, 0);
            chk("rst_short", o_err_short, 0);
            chk("rst_ovr", o_err_ovr, 0);
        end
        rst_n = 1'b1; i_valid = 1'b0; i_sop = 1'b0;
    endtask

    task automatic frame(input int re, input int im);
        for (int b = 0; b < NFFT; b++) step(1'b1, b == 0, re, im);
    endtask

    task automatic frame_rand();
        int re;
        int im;
        for (int b = 0; b < NFFT; b++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 0, 0);
            re = int'($urandom_range(0, 65535)) - 32768;
            im = int'($urandom_range(0, 65535)) - 32768;
            step(1'b1, b == 0, re, im);
        end
    endtask

    task automatic drain();
        repeat (6) step(1'b0, 1'b0, 0, 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    vec_t tbl [5];

    initial begin
        tbl = '{'{3, 4, 25},
                '{-32768, -32768, 64'h8000_0000},
                '{0, 0, 1},
                '{32767, -32768, 2147418113},
                '{-1, 1, 2}};

        do_reset(5);

        // valid without sop while idle must be ignored
        repeat (3) step(1'b1, 1'b0, 9, 9);
        repeat (2) step(1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            n_en = 0;
            repeat (NFR) frame(tbl[i].re, tbl[i].im);
            drain();
            chk("tbl_en_count", n_en, 8);
            chk("tbl_power", last_pwr, tbl[i].pwr);
        end

        // bin 2 sees p = 1, 2, 4, 4 -> (11 >> 2) = 2
        pwr_bin2 = 0;
        for (int f = 0; f < NFR; f++) begin
            for (int b = 0; b < NFFT; b++) begin
                case (f)
                    0: step(1'b1, b == 0, (b == 2) ? 1 : 0, 0);
                    1: step(1'b1, b == 0, (b == 2) ? 1 : 0, (b == 2) ? 1 : 0);
                    2: step(1'b1, b == 0, (b == 2) ? 2 : 0, 0);
                    default: step(1'b1, b == 0, 0, (b == 2) ? 2 : 0);
                endcase
            end
        end
        drain();
        chk("avg_trunc_bin2", pwr_bin2, 2);

        // short frame: sop arrives at bin 5 of frame 2
        frame(100, 0);
        frame(100, 0);
        for (int b = 0; b < 5; b++) step(1'b1, b == 0, 100, 0);
        n_en = 0; n_short = 0;
        repeat (NFR) frame(5, 0);
        drain();
        chk("short_count", n_short, 1);
        chk("short_en_count", n_en, 8);
        chk("short_power", last_pwr, 25);

        // overrun: ninth valid without sop
        n_en = 0; n_ovr = 0;
        frame(7, 0);
        step(1'b1, 1'b0, 9, 9);
        step(1'b1, 1'b0, 9, 9);
        step(1'b1, 1'b0, 9, 9);
        drain();
        chk("ovr_count", n_ovr, 1);
        chk("ovr_en_count", n_en, 0);

        // random gaps and values
        n_en = 0;
        repeat (2 * NFR) frame_rand();
        drain();
        chk("rand_en_count", n_en, 16);

        // reset mid last frame: in-flight results are discarded
        repeat (NFR - 1) frame(6, 8);
        for (int b = 0; b < 5; b++) step(1'b1, b == 0, 6, 8);
        do_reset(3);
        n_en = 0;
        step(1'b1, 1'b0, 1, 1);
        repeat (NFR) frame(2, 3);
        drain();
        chk("post_reset_en_count", n_en, 8);
        chk("post_reset_power", last_pwr, 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
